// File: rtl/quan_pack_wb_if.sv
// rtl/quan_pack_wb_if.sv - byte-in / packed-word-out handshake bundle for quan_pack_wb
//
// Purpose: groups the re-quantizer byte stream and the SRAM write port.
// Signals:
//   q_in, q_valid_in, q_ready_out   serial uint8 input handshake
//   wr_valid, wr_ready              SRAM write handshake
//   wr_addr, wr_data                SRAM word address and packed word
//   wr_bmask                        lane-valid mask (QUAN_PACK_BYTE_MASK_EN only)
// Modports: master = packer side, slave = environment side.
interface quan_pack_wb_if #(
   parameter int LANES  = 8,
   parameter int ADDR_W = 16
);
   logic [7:0]         q_in;
   logic               q_valid_in;
   logic               q_ready_out;
   logic               wr_valid;
   logic               wr_ready;
   logic [ADDR_W-1:0]  wr_addr;
   logic [8*LANES-1:0] wr_data;
`ifdef QUAN_PACK_BYTE_MASK_EN
   logic [LANES-1:0]   wr_bmask;

   modport master (
      input  q_in, q_valid_in, wr_ready,
      output q_ready_out, wr_valid, wr_addr, wr_data, wr_bmask
   );
   modport slave (
      output q_in, q_valid_in, wr_ready,
      input  q_ready_out, wr_valid, wr_addr, wr_data, wr_bmask
   );
`else
   modport master (
      input  q_in, q_valid_in, wr_ready,
      output q_ready_out, wr_valid, wr_addr, wr_data
   );
   modport slave (
      output q_in, q_valid_in, wr_ready,
      input  q_ready_out, wr_valid, wr_addr, wr_data
   );
`endif
endinterface

// File: rtl/quan_pack_wb.sv
// rtl/quan_pack_wb.sv - packs serial uint8 results into words and writes them to SRAM
//
// Purpose: collects one byte per accepted cycle into LANES-byte little-endian
// words, buffers them in a show-ahead FIFO and drains them to the SRAM write
// port at base_addr, base_addr+1, ... One tile per start pulse.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                begin a tile (IDLE only); latches base_addr, tile_len
//   base_addr, tile_len  first word address, tile byte count
//   bus (master)         byte input handshake and SRAM write port
//   busy                 state != IDLE
//   done                 one-cycle pulse at tile end
// Optional: QUAN_PACK_BYTE_MASK_EN adds bus.wr_bmask, carried through the FIFO.
module quan_pack_wb #(
   parameter int LANES      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16,
   parameter int LEN_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  tile_len,
   quan_pack_wb_if.master    bus,
   output logic              busy,
   output logic              done
);
   localparam int W      = 8 * LANES;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d, pop_cnt_q, pop_cnt_d;
   logic [LEN_W-1:0]  len_q, len_d, byte_cnt_q, byte_cnt_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [W-1:0]      asm_q, asm_d;
   logic [W-1:0]      mem_q [FIFO_DEPTH];
   logic [W-1:0]      mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
`ifdef QUAN_PACK_BYTE_MASK_EN
   logic [LANES-1:0]  mask_q [FIFO_DEPTH];
   logic [LANES-1:0]  mask_d [FIFO_DEPTH];
   logic [LANES-1:0]  push_mask;
`endif

   logic         q_ready, accept, last_byte, push, pop;
   logic [W-1:0] push_word;

   assign q_ready   = (state_q == S_RUN) && (cnt_q < (PTR_W+1)'(FIFO_DEPTH));
   assign accept    = bus.q_valid_in && q_ready;
   assign last_byte = (byte_cnt_q == len_q - LEN_W'(1));
   // A word leaves assembly when its top lane fills or the tile runs out.
   assign push      = accept && ((lane_q == LANE_W'(LANES - 1)) || last_byte);
   assign pop       = (cnt_q != '0) && bus.wr_ready;

   // State register (with all other flops)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         byte_cnt_q <= '0;
         pop_cnt_q  <= '0;
         lane_q     <= '0;
         asm_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
`ifdef QUAN_PACK_BYTE_MASK_EN
            mask_q[i] <= '0;
`endif
         end
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         byte_cnt_q <= byte_cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         lane_q     <= lane_d;
         asm_q      <= asm_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
`ifdef QUAN_PACK_BYTE_MASK_EN
         mask_q     <= mask_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (tile_len == '0) ? S_DONE : S_RUN;
         S_RUN:   if (accept && last_byte) state_d = S_FLUSH;
         // Empty count here means the final pop already happened at the last edge.
         S_FLUSH: if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy            = (state_q != S_IDLE);
      done            = (state_q == S_DONE);
      bus.q_ready_out = q_ready;
      bus.wr_valid    = (cnt_q != '0);
      bus.wr_addr     = base_q + pop_cnt_q;
      bus.wr_data     = mem_q[rd_ptr_q];
`ifdef QUAN_PACK_BYTE_MASK_EN
      bus.wr_bmask    = mask_q[rd_ptr_q];
`endif
   end

   // Datapath: word assembly, counters, FIFO
   always_comb begin
      base_d     = base_q;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      pop_cnt_d  = pop_cnt_q;
      lane_d     = lane_q;
      asm_d      = asm_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      mem_d      = mem_q;
      push_word  = asm_q;
      push_word[{lane_q, 3'b000} +: 8] = bus.q_in;
`ifdef QUAN_PACK_BYTE_MASK_EN
      mask_d     = mask_q;
      for (int i = 0; i < LANES; i++) push_mask[i] = (LANE_W'(i) <= lane_q);
`endif

      if ((state_q == S_IDLE) && start) begin
         base_d     = base_addr;
         len_d      = tile_len;
         byte_cnt_d = '0;
         pop_cnt_d  = '0;
         lane_d     = '0;
         asm_d      = '0;
      end

      if (accept) begin
         byte_cnt_d = byte_cnt_q + 1'b1;
         if (push) begin
            lane_d = '0;
            asm_d  = '0;   // unfilled lanes of the next word start as zero padding
         end else begin
            lane_d = lane_q + 1'b1;
            asm_d  = push_word;
         end
      end

      if (push) begin
         mem_d[wr_ptr_q] = push_word;
`ifdef QUAN_PACK_BYTE_MASK_EN
         mask_d[wr_ptr_q] = push_mask;
`endif
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (pop) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         pop_cnt_d = pop_cnt_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end
endmodule

// File: tb/tb_quan_pack_wb.sv
// tb/tb_quan_pack_wb.sv - scoreboard testbench for quan_pack_wb
module tb_quan_pack_wb;
   localparam int LANES = 8;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] tile_len;
   logic        busy;
   logic        done;

   quan_pack_wb_if #(.LANES(LANES), .ADDR_W(16)) bus ();

   quan_pack_wb #(.LANES(LANES), .FIFO_DEPTH(DEPTH), .ADDR_W(16), .LEN_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .tile_len(tile_len), .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [63:0] data;
      logic [7:0]  mask;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   fails = 0;
   int   done_cnt = 0;
   int   accepted = 0;
   int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: slice the byte list into little-endian words, zero padded.
   task automatic expect_tile(input logic [15:0] base, input logic [7:0] b[$]);
      int   n;
      int   nw;
      exp_t e;
      n  = b.size();
      nw = (n + LANES - 1) / LANES;
      for (int w = 0; w < nw; w++) begin
         e.addr = 16'(int'(base) + w);
         e.data = '0;
         e.mask = '0;
         for (int l = 0; l < LANES; l++) begin
            if (w * LANES + l < n) begin
               e.data[l*8 +: 8] = b[w * LANES + l];
               e.mask[l]        = 1'b1;
            end
         end
         sb_q.push_back(e);
      end
   endtask

   // wr_ready driver
   initial begin
      bus.wr_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.wr_ready = 1'b1;
            1:       bus.wr_ready = 1'b0;
            default: bus.wr_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the scoreboard on each completed write
   initial begin
      logic        prev_stall;
      logic [15:0] prev_addr;
      logic [63:0] prev_data;
      exp_t        e;
      prev_stall = 1'b0;
      prev_addr  = '0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
               chk("hold_valid", 64'(bus.wr_valid), 64'd1);
               chk("hold_addr", 64'(bus.wr_addr), 64'(prev_addr));
               chk("hold_data", bus.wr_data, prev_data);
            end
            if (bus.wr_valid && bus.wr_ready) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none",
                           bus.wr_addr, bus.wr_data);
               end else begin
                  e = sb_q.pop_front();
                  chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                  chk("wr_data", bus.wr_data, e.data);
`ifdef QUAN_PACK_BYTE_MASK_EN
                  chk("wr_bmask", 64'(bus.wr_bmask), 64'(e.mask));
`endif
               end
            end
            prev_stall = bus.wr_valid && !bus.wr_ready;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
         end
      end
   end

   task automatic start_tile(input logic [15:0] base, input logic [15:0] len);
      start     = 1'b1;
      base_addr = base;
      tile_len  = len;
      @(posedge clk);
      #1;
      start     = 1'b0;
      base_addr = $urandom;
      tile_len  = $urandom;
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic send(input logic [7:0] b[$], input int gap_pct);
      logic acc;
      int   t;
      for (int i = 0; i < b.size(); i++) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            bus.q_valid_in = 1'b0;
            bus.q_in       = 8'($urandom);
            @(posedge clk);
            #1;
         end
         bus.q_valid_in = 1'b1;
         bus.q_in       = b[i];
         t = 0;
         acc = 1'b0;
         while (!acc && t < 2000) begin
            @(negedge clk);
            acc = bus.q_ready_out;
            @(posedge clk);
            #1;
            t++;
         end
         if (!acc) begin
            chk("byte_accept_timeout", 64'd0, 64'd1);
            break;
         end
         accepted++;
      end
      bus.q_valid_in = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
   endtask

   // stall > 0: hold wr_ready low until the FIFO fills, then switch to after_mode.
   task automatic run_tile(input logic [15:0] base, input logic [7:0] b[$], input int gap_pct,
                           input int mode, input bit check_lat, input int stall, input int after_mode);
      int d0;
      int a0;
      rdy_mode = mode;
      @(posedge clk);
      #1;
      expect_tile(base, b);
      d0 = done_cnt;
      a0 = accepted;
      start_tile(base, 16'(b.size()));
      fork
         send(b, gap_pct);
         begin
            if (check_lat) begin
               int c;
               c = 0;
               do begin
                  @(negedge clk);
                  c++;
               end while (!bus.wr_valid && c < 50);
               chk("first_write_latency", 64'(c), 64'(1 + LANES));
            end
         end
         begin
            if (stall > 0) begin
               repeat (stall) @(posedge clk);
               @(negedge clk);
               chk("full_q_ready", 64'(bus.q_ready_out), 64'd0);
               chk("full_accepted", 64'(accepted - a0), 64'(LANES * DEPTH));
               rdy_mode = after_mode;
            end
         end
      join
      wait_done(d0);
   endtask

   initial begin
      logic [7:0] b[$];
      logic [7:0] b48[$];
      int         d0;

      reset          = 1'b1;
      start          = 1'b0;
      base_addr      = '0;
      tile_len       = '0;
      bus.q_in       = '0;
      bus.q_valid_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
      chk("rst_q_ready", 64'(bus.q_ready_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
      chk("rst_wr_data", bus.wr_data, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Two full words, back-to-back, with first-write latency
      b = {};
      for (int i = 1; i <= 16; i++) b.push_back(8'(i));
      run_tile(16'h0100, b, 0, 0, 1'b1, 0, 0);

      // Partial last word
      b = {};
      for (int i = 1; i <= 11; i++) b.push_back(8'(i));
      run_tile(16'h0200, b, 0, 0, 1'b0, 0, 0);

      // Backpressure: fill FIFO, then release; then random ready on the same data
      b48 = {};
      for (int i = 0; i < 48; i++) b48.push_back(8'($urandom));
      run_tile(16'h0400, b48, 0, 1, 1'b0, 45, 0);
      run_tile(16'h0400, b48, 20, 2, 1'b0, 0, 0);

      // Zero-length tile, with q_valid_in asserted throughout
      rdy_mode = 0;
      d0 = done_cnt;
      bus.q_valid_in = 1'b1;
      bus.q_in       = 8'hAA;
      start_tile(16'h0500, 16'd0);
      @(negedge clk);
      chk("zero_q_ready", 64'(bus.q_ready_out), 64'd0);
      chk("zero_done_first_cycle", 64'(done), 64'd1);
      @(negedge clk);
      chk("zero_q_ready_2", 64'(bus.q_ready_out), 64'd0);
      @(posedge clk);
      #1;
      bus.q_valid_in = 1'b0;
      wait_done(d0);

      // Reset abort after 5 of 16 bytes
      b = {};
      for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
      expect_tile(16'h0600, b);
      d0 = done_cnt;
      start_tile(16'h0600, 16'd16);
      send(b[0:4], 0);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_wr_valid", 64'(bus.wr_valid), 64'd0);
      chk("abort_q_ready", 64'(bus.q_ready_out), 64'd0);
      chk("abort_wr_addr", 64'(bus.wr_addr), 64'd0);
      chk("abort_wr_data", bus.wr_data, 64'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      b = {};
      for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
      run_tile(16'h0ABC, b, 0, 0, 1'b0, 0, 0);

      // Start ignored mid-RUN
      b = {};
      for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
      rdy_mode = 0;
      expect_tile(16'h0300, b);
      d0 = done_cnt;
      start_tile(16'h0300, 16'd16);
      fork
         send(b, 0);
         begin
            repeat (3) @(posedge clk);
            #2;
            start     = 1'b1;
            base_addr = 16'h7777;
            tile_len  = 16'd5;
            @(posedge clk);
            #2;
            start     = 1'b0;
         end
      join
      wait_done(d0);

      // Random tiles, including an address wrap
      for (int k = 0; k < 6; k++) begin
         logic [15:0] base;
         int          len;
         len  = $urandom_range(1, 40);
         base = (k == 0) ? 16'hFFFE : 16'($urandom);
         b = {};
         for (int i = 0; i < len; i++) b.push_back(8'($urandom));
         run_tile(base, b, $urandom_range(0, 30), (k % 2 == 0) ? 2 : 0, 1'b0, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
